// File: rtl/fp_mul_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_pkg
// Shared types and helpers for the multi-lane significand multiply pipeline.
//   mul_mode_t     : per-thread multiplier mode (EXACT, LB, DTCL, RSVD)
//   mul_op_t       : operation encoding carried with each op
//   MUL_STAGES_MAX : deepest supported pipeline
//   lb_afpm_lite   : logarithm-based approximate 32x32 product
//   dtcl_afpm_lite : dynamic-truncation approximate 32x32 product
// -----------------------------------------------------------------------------
package fp_mul_pkg;

    typedef enum logic [1:0] {
        EXACT = 2'd0,
        LB    = 2'd1,
        DTCL  = 2'd2,
        RSVD  = 2'd3
    } mul_mode_t;

    typedef enum logic [1:0] {
        MUL_F  = 2'd0,
        MULL_I = 2'd1,
        MULH_U = 2'd2,
        MULH_I = 2'd3
    } mul_op_t;

    localparam int MUL_STAGES_MAX = 4;

    // Number of significant bits (counting the leading one) that the
    // truncating unit keeps from each operand.
    localparam int DTCL_KEEP = 8;

    // Position of the most significant set bit; 0 for an all-zero input.
    function automatic logic [4:0] lead_one(input logic [31:0] x);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) pos = 5'(i);
        end
        return pos;
    endfunction

    // Linearised logarithmic product: writing a = 2^ka + fa and
    // b = 2^kb + fb, the exact product is 2^(ka+kb) + fa*2^kb + fb*2^ka
    // + fa*fb.  The cross term fa*fb is dropped, so the result never
    // exceeds the exact product and needs no multiplier at all.
    function automatic logic [63:0] lb_afpm_lite(input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [4:0]  ka;
        logic [4:0]  kb;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [63:0] r;
        ka = lead_one(a);
        kb = lead_one(b);
        fa = a & ~(32'd1 << ka);
        fb = b & ~(32'd1 << kb);
        if (a == 32'd0 || b == 32'd0) begin
            r = 64'd0;
        end else begin
            r = (64'd1 << ({1'b0, ka} + {1'b0, kb}))
              + ({32'd0, fa} << kb)
              + ({32'd0, fb} << ka);
        end
        return r;
    endfunction

    // Keep only the DTCL_KEEP bits starting at the leading one; operands
    // narrower than that pass through untouched.
    function automatic logic [31:0] dtcl_trunc(input logic [31:0] x);
        logic [4:0]  k;
        logic [31:0] keep_mask;
        k = lead_one(x);
        if (k >= 5'(DTCL_KEEP)) begin
            keep_mask = ~32'd0 << (k - 5'(DTCL_KEEP - 1));
        end else begin
            keep_mask = ~32'd0;
        end
        return x & keep_mask;
    endfunction

    // Product of the dynamically truncated operands.
    function automatic logic [63:0] dtcl_afpm_lite(input logic [31:0] a,
                                                   input logic [31:0] b);
        return {32'd0, dtcl_trunc(a)} * {32'd0, dtcl_trunc(b)};
    endfunction

endpackage

// File: rtl/fp_mul_lane.sv
// -----------------------------------------------------------------------------
// fp_mul_lane
// One lane of the multiply datapath (purely combinational).
//   op      in  2   operation (mul_op_t encoding)
//   mode    in  2   multiplier mode sampled at issue (mul_mode_t encoding)
//   a       in  32  multiplicand
//   b       in  32  multiplier
//   product out 64  selected product
// -----------------------------------------------------------------------------
module fp_mul_lane
    import fp_mul_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  mode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] exact_product;

    // Only the signed high multiply sign-extends; the low 64 bits of the
    // 64x64 product are then the full signed 32x32 result.
    always_comb begin
        ext_a = {32'd0, a};
        ext_b = {32'd0, b};
        if (op == MULH_I) begin
            ext_a = {{32{a[31]}}, a};
            ext_b = {{32{b[31]}}, b};
        end
        exact_product = ext_a * ext_b;
    end

    // Approximate units only serve MUL_F; the reserved mode falls back to
    // the exact multiplier.
    always_comb begin
        product = exact_product;
        if (op == MUL_F) begin
            case (mode)
                LB:      product = lb_afpm_lite(a, b);
                DTCL:    product = dtcl_afpm_lite(a, b);
                default: product = exact_product;
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Multi-lane significand multiply pipeline with per-thread multiplier mode,
// per-thread rollback squash and retired MUL_F statistics.
//   clk, reset_n                      clock, async active-low reset
//   cfg_mode_we/thread/value          per-thread mode table write
//   in_valid, in_thread_idx, in_op    issued operation
//   in_mask, in_sideband              carried alongside the op
//   in_multiplicand, in_multiplier    per-lane 32-bit operands
//   rollback_en, rollback_thread_idx  squash every in-flight op of a thread
//   out_valid, out_thread_idx         retiring op, MUL_STAGES cycles later
//   out_mask, out_sideband            delayed copies of the inputs
//   out_product                       per-lane 64-bit products
//   out_approx                        product came from an approximate unit
//   stat_clear                        zero both counters
//   stat_fmul_exact/stat_fmul_approx  saturating retired MUL_F counters
// -----------------------------------------------------------------------------
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int NUM_LANES   = 16,
    parameter int MUL_STAGES  = 2,
    parameter int NUM_THREADS = 4,
    parameter int THREAD_W    = $clog2(NUM_THREADS),
    parameter int SIDEBAND_W  = 8,
    parameter int STAT_W      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cfg_mode_we,
    input  logic [THREAD_W-1:0]       cfg_mode_thread,
    input  logic [1:0]                cfg_mode_value,
    input  logic                      in_valid,
    input  logic [THREAD_W-1:0]       in_thread_idx,
    input  logic [1:0]                in_op,
    input  logic [NUM_LANES-1:0]      in_mask,
    input  logic [NUM_LANES*32-1:0]   in_multiplicand,
    input  logic [NUM_LANES*32-1:0]   in_multiplier,
    input  logic [SIDEBAND_W-1:0]     in_sideband,
    input  logic                      rollback_en,
    input  logic [THREAD_W-1:0]       rollback_thread_idx,
    output logic                      out_valid,
    output logic [THREAD_W-1:0]       out_thread_idx,
    output logic [NUM_LANES-1:0]      out_mask,
    output logic [SIDEBAND_W-1:0]     out_sideband,
    output logic [NUM_LANES*64-1:0]   out_product,
    output logic                      out_approx,
    input  logic                      stat_clear,
    output logic [STAT_W-1:0]         stat_fmul_exact,
    output logic [STAT_W-1:0]         stat_fmul_approx
);

    // Depths outside 1..MUL_STAGES_MAX are clamped into range.
    localparam int STAGES = (MUL_STAGES > MUL_STAGES_MAX) ? MUL_STAGES_MAX :
                            (MUL_STAGES < 1)              ? 1 : MUL_STAGES;

    logic [1:0]                  mode_table [NUM_THREADS];
    logic [1:0]                  issue_mode;
    logic                        issue_approx;
    logic [NUM_LANES*64-1:0]     lane_product;

    logic [STAGES-1:0]           st_valid;
    logic [STAGES-1:0]           st_approx;
    logic [THREAD_W-1:0]         st_thread  [STAGES];
    logic [1:0]                  st_op      [STAGES];
    logic [NUM_LANES-1:0]        st_mask    [STAGES];
    logic [SIDEBAND_W-1:0]       st_sband   [STAGES];
    logic [NUM_LANES*64-1:0]     st_product [STAGES];

    logic [1:0]                  out_op;
    logic                        retire_fmul;

    // Mode table: the issue path reads the registered value, so an op
    // issued in the same cycle as a write to its thread sees the old mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                mode_table[t] <= EXACT;
            end
        end else if (cfg_mode_we) begin
            mode_table[cfg_mode_thread] <= cfg_mode_value;
        end
    end

    // Mode is frozen into the op at issue; only the approx flag and the
    // already-selected product travel down the pipe.
    always_comb begin
        issue_mode   = mode_table[in_thread_idx];
        issue_approx = (in_op == MUL_F) && ((issue_mode == LB) || (issue_mode == DTCL));
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        fp_mul_lane u_lane (
            .op      (in_op),
            .mode    (issue_mode),
            .a       (in_multiplicand[l*32 +: 32]),
            .b       (in_multiplier[l*32 +: 32]),
            .product (lane_product[l*64 +: 64])
        );
    end

    // Valid chain.  A rollback clears every valid belonging to the named
    // thread as it moves to the next stage, which also covers the op being
    // issued and the op about to reach the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= in_valid &&
                           !(rollback_en && (in_thread_idx == rollback_thread_idx));
            for (int i = 1; i < STAGES; i++) begin
                st_valid[i] <= st_valid[i-1] &&
                               !(rollback_en && (st_thread[i-1] == rollback_thread_idx));
            end
        end
    end

    // Data chain.  The whole product is formed in front of the first
    // register and then simply delayed; rollback leaves these untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_approx <= '0;
            for (int i = 0; i < STAGES; i++) begin
                st_thread[i]  <= '0;
                st_op[i]      <= '0;
                st_mask[i]    <= '0;
                st_sband[i]   <= '0;
                st_product[i] <= '0;
            end
        end else begin
            st_approx[0]  <= issue_approx;
            st_thread[0]  <= in_thread_idx;
            st_op[0]      <= in_op;
            st_mask[0]    <= in_mask;
            st_sband[0]   <= in_sideband;
            st_product[0] <= lane_product;
            for (int i = 1; i < STAGES; i++) begin
                st_approx[i]  <= st_approx[i-1];
                st_thread[i]  <= st_thread[i-1];
                st_op[i]      <= st_op[i-1];
                st_mask[i]    <= st_mask[i-1];
                st_sband[i]   <= st_sband[i-1];
                st_product[i] <= st_product[i-1];
            end
        end
    end

    assign out_valid      = st_valid[STAGES-1];
    assign out_approx     = st_approx[STAGES-1];
    assign out_thread_idx = st_thread[STAGES-1];
    assign out_mask       = st_mask[STAGES-1];
    assign out_sideband   = st_sband[STAGES-1];
    assign out_product    = st_product[STAGES-1];
    assign out_op         = st_op[STAGES-1];
    assign retire_fmul    = out_valid && (out_op == MUL_F);

    // Statistics: count MUL_F ops as they leave the output register.
    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_fmul_exact  <= '0;
            stat_fmul_approx <= '0;
        end else if (stat_clear) begin
            stat_fmul_exact  <= '0;
            stat_fmul_approx <= '0;
        end else if (retire_fmul) begin
            if (out_approx) begin
                if (!(&stat_fmul_approx)) stat_fmul_approx <= stat_fmul_approx + STAT_W'(1);
            end else begin
                if (!(&stat_fmul_exact)) stat_fmul_exact <= stat_fmul_exact + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
// Self-checking bench for fp_mul_pipe built with three stages, four threads
// and 4-bit statistics counters.  A scoreboard predicts each cycle's output
// from the issue history, and hand-written vectors pin down known products.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;
    import fp_mul_pkg::*;

    localparam int NL  = 16;
    localparam int S   = 3;
    localparam int NT  = 4;
    localparam int TW  = 2;
    localparam int SBW = 8;
    localparam int SW  = 4;

    logic              clk;
    logic              reset_n;
    logic              cfg_mode_we;
    logic [TW-1:0]     cfg_mode_thread;
    logic [1:0]        cfg_mode_value;
    logic              in_valid;
    logic [TW-1:0]     in_thread_idx;
    logic [1:0]        in_op;
    logic [NL-1:0]     in_mask;
    logic [NL*32-1:0]  in_multiplicand;
    logic [NL*32-1:0]  in_multiplier;
    logic [SBW-1:0]    in_sideband;
    logic              rollback_en;
    logic [TW-1:0]     rollback_thread_idx;
    logic              out_valid;
    logic [TW-1:0]     out_thread_idx;
    logic [NL-1:0]     out_mask;
    logic [SBW-1:0]    out_sideband;
    logic [NL*64-1:0]  out_product;
    logic              out_approx;
    logic              stat_clear;
    logic [SW-1:0]     stat_fmul_exact;
    logic [SW-1:0]     stat_fmul_approx;

    fp_mul_pipe #(
        .NUM_LANES   (NL),
        .MUL_STAGES  (S),
        .NUM_THREADS (NT),
        .THREAD_W    (TW),
        .SIDEBAND_W  (SBW),
        .STAT_W      (SW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cfg_mode_we         (cfg_mode_we),
        .cfg_mode_thread     (cfg_mode_thread),
        .cfg_mode_value      (cfg_mode_value),
        .in_valid            (in_valid),
        .in_thread_idx       (in_thread_idx),
        .in_op               (in_op),
        .in_mask             (in_mask),
        .in_multiplicand     (in_multiplicand),
        .in_multiplier       (in_multiplier),
        .in_sideband         (in_sideband),
        .rollback_en         (rollback_en),
        .rollback_thread_idx (rollback_thread_idx),
        .out_valid           (out_valid),
        .out_thread_idx      (out_thread_idx),
        .out_mask            (out_mask),
        .out_sideband        (out_sideband),
        .out_product         (out_product),
        .out_approx          (out_approx),
        .stat_clear          (stat_clear),
        .stat_fmul_exact     (stat_fmul_exact),
        .stat_fmul_approx    (stat_fmul_approx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One in-flight op as the scoreboard sees it.
    typedef struct packed {
        int               issue;
        logic [TW-1:0]    thread;
        logic [1:0]       op;
        logic [NL-1:0]    mask;
        logic [SBW-1:0]   sb;
        logic             approx;
        logic [NL*64-1:0] prod;
        bit               squashed;
    } op_rec_t;

    // Hand-computed vector: same operands on every lane.
    typedef struct packed {
        logic [1:0]     op;
        logic [TW-1:0]  thread;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [NL-1:0]  mask;
        logic [SBW-1:0] sb;
        logic [63:0]    exp_prod;
        logic           exp_approx;
    } vec_t;

    vec_t        vecs [8];
    op_rec_t     pend [$];
    op_rec_t     exp_cur;
    bit          exp_valid;
    logic [1:0]  mode_m [NT];
    int unsigned cnt_exact;
    int unsigned cnt_approx;
    int          cyc;
    int          total;
    int          bad;
    bit          ovr_en;
    logic [63:0] ovr_prod;
    logic        ovr_approx;

    // ---------------- reference arithmetic ----------------
    function automatic int flog2(logic [31:0] x);
        return $clog2({32'd0, x} + 64'd1) - 1;
    endfunction

    function automatic logic [63:0] dtrunc(logic [31:0] x);
        int k;
        if (x == 32'd0) return 64'd0;
        k = flog2(x);
        if (k < 8) return {32'd0, x};
        return ({32'd0, x} >> (k - 7)) << (k - 7);
    endfunction

    function automatic logic [63:0] model_product(logic [1:0] op, logic [1:0] mode,
                                                  logic [31:0] a, logic [31:0] b);
        longint      sx;
        longint      sy;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] pa;
        logic [63:0] pb;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == MULH_I) begin
            sx = longint'($signed(a));
            sy = longint'($signed(b));
            return 64'(sx * sy);
        end
        if (op != MUL_F || mode == EXACT || mode == RSVD) return ua * ub;
        if (mode == LB) begin
            if (a == 32'd0 || b == 32'd0) return 64'd0;
            pa = 64'd1 << flog2(a);
            pb = 64'd1 << flog2(b);
            return ua * ub - (ua - pa) * (ub - pb);
        end
        return dtrunc(a) * dtrunc(b);
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic compare(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_product(string name, logic [NL*64-1:0] act, logic [NL*64-1:0] exp);
        int bl;
        bl = -1;
        total++;
        for (int l = NL - 1; l >= 0; l--) begin
            if (act[l*64 +: 64] !== exp[l*64 +: 64]) bl = l;
        end
        if (bl >= 0) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d lane=%0d got=0x%0h expected=0x%0h",
                     name, cyc, bl, act[bl*64 +: 64], exp[bl*64 +: 64]);
        end
    endtask

    task automatic drive_idle();
        cfg_mode_we         = 1'b0;
        cfg_mode_thread     = '0;
        cfg_mode_value      = 2'd0;
        in_valid            = 1'b0;
        in_thread_idx       = '0;
        in_op               = 2'd0;
        in_mask             = '0;
        in_multiplicand     = '0;
        in_multiplier       = '0;
        in_sideband         = '0;
        rollback_en         = 1'b0;
        rollback_thread_idx = '0;
        stat_clear          = 1'b0;
    endtask

    task automatic set_issue(logic [TW-1:0] t, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                             logic [NL-1:0] m, logic [SBW-1:0] sb);
        in_valid      = 1'b1;
        in_thread_idx = t;
        in_op         = op;
        in_mask       = m;
        in_sideband   = sb;
        for (int l = 0; l < NL; l++) begin
            in_multiplicand[l*32 +: 32] = a;
            in_multiplier[l*32 +: 32]   = b;
        end
    endtask

    function automatic int unsigned sat_inc(int unsigned v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    // Compare the DUT outputs of the current cycle against the scoreboard.
    task automatic checkOutput();
        exp_valid = 1'b0;
        while (pend.size() > 0 && pend[0].issue < cyc - S) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].issue == cyc - S) begin
            exp_cur   = pend.pop_front();
            exp_valid = !exp_cur.squashed;
        end
        compare("stat_exact", 64'(stat_fmul_exact), 64'(cnt_exact));
        compare("stat_approx", 64'(stat_fmul_approx), 64'(cnt_approx));
        compare("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            compare("out_thread", 64'(out_thread_idx), 64'(exp_cur.thread));
            compare("out_mask", 64'(out_mask), 64'(exp_cur.mask));
            compare("out_sideband", 64'(out_sideband), 64'(exp_cur.sb));
            compare("out_approx", 64'(out_approx), 64'(exp_cur.approx));
            compare_product("out_product", out_product, exp_cur.prod);
        end
    endtask

    // Update the model with the inputs currently driven, clock once, check.
    task automatic applyStimulus();
        op_rec_t r;
        logic [1:0] md;
        if (in_valid) begin
            md        = mode_m[in_thread_idx];
            r.issue   = cyc;
            r.thread  = in_thread_idx;
            r.op      = in_op;
            r.mask    = in_mask;
            r.sb      = in_sideband;
            r.approx  = (in_op == MUL_F) && (md == LB || md == DTCL);
            r.squashed = 1'b0;
            for (int l = 0; l < NL; l++) begin
                r.prod[l*64 +: 64] = model_product(in_op, md, in_multiplicand[l*32 +: 32],
                                                   in_multiplier[l*32 +: 32]);
            end
            if (ovr_en) begin
                r.approx = ovr_approx;
                for (int l = 0; l < NL; l++) r.prod[l*64 +: 64] = ovr_prod;
            end
            pend.push_back(r);
        end
        if (rollback_en) begin
            foreach (pend[i]) begin
                if (pend[i].thread == rollback_thread_idx && pend[i].issue >= cyc - (S - 1))
                    pend[i].squashed = 1'b1;
            end
        end
        if (cfg_mode_we) mode_m[cfg_mode_thread] = cfg_mode_value;
        if (stat_clear) begin
            cnt_exact  = 0;
            cnt_approx = 0;
        end else if (exp_valid && exp_cur.op == MUL_F) begin
            if (exp_cur.approx) cnt_approx = sat_inc(cnt_approx);
            else                cnt_exact  = sat_inc(cnt_exact);
        end
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            applyStimulus();
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_valid  = 1'b0;
        cnt_exact  = 0;
        cnt_approx = 0;
        for (int t = 0; t < NT; t++) mode_m[t] = EXACT;
    endtask

    task automatic check_all_zero(string tag);
        compare({tag, "_valid"}, 64'(out_valid), 64'd0);
        compare({tag, "_thread"}, 64'(out_thread_idx), 64'd0);
        compare({tag, "_mask"}, 64'(out_mask), 64'd0);
        compare({tag, "_sideband"}, 64'(out_sideband), 64'd0);
        compare({tag, "_approx"}, 64'(out_approx), 64'd0);
        compare_product({tag, "_product"}, out_product, '0);
        compare({tag, "_stat_exact"}, 64'(stat_fmul_exact), 64'd0);
        compare({tag, "_stat_approx"}, 64'(stat_fmul_approx), 64'd0);
    endtask

    initial begin
        vecs[0] = '{op:MULH_I, thread:2'd0, a:32'hFFFF_FFFE, b:32'd3,          mask:16'hFFFF, sb:8'h11,
                    exp_prod:64'hFFFF_FFFF_FFFF_FFFA, exp_approx:1'b0};
        vecs[1] = '{op:MULL_I, thread:2'd3, a:32'h0001_0000, b:32'h0001_0000, mask:16'h00FF, sb:8'hA5,
                    exp_prod:64'h0000_0001_0000_0000, exp_approx:1'b0};
        vecs[2] = '{op:MULH_U, thread:2'd1, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, mask:16'h8001, sb:8'h3C,
                    exp_prod:64'hFFFF_FFFE_0000_0001, exp_approx:1'b0};
        vecs[3] = '{op:MULH_I, thread:2'd2, a:32'h8000_0000, b:32'h8000_0000, mask:16'h0F0F, sb:8'h5A,
                    exp_prod:64'h4000_0000_0000_0000, exp_approx:1'b0};
        vecs[4] = '{op:MUL_F,  thread:2'd0, a:32'h1234_5678, b:32'h0000_0010, mask:16'hFFFF, sb:8'h01,
                    exp_prod:64'h0000_0001_2345_6780, exp_approx:1'b0};
        vecs[5] = '{op:MULH_I, thread:2'd3, a:32'h7FFF_FFFF, b:32'hFFFF_FFFF, mask:16'h1234, sb:8'hFF,
                    exp_prod:64'hFFFF_FFFF_8000_0001, exp_approx:1'b0};
        vecs[6] = '{op:MULL_I, thread:2'd1, a:32'h0000_0000, b:32'hDEAD_BEEF, mask:16'hFFFF, sb:8'h77,
                    exp_prod:64'h0, exp_approx:1'b0};
        vecs[7] = '{op:MUL_F,  thread:2'd0, a:32'h0000_0000, b:32'hFFFF_FFFF, mask:16'h0001, sb:8'h80,
                    exp_prod:64'h0, exp_approx:1'b0};

        total  = 0;
        bad    = 0;
        cyc    = 0;
        ovr_en = 1'b0;
        model_reset();
        drive_idle();

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Hand vectors; the first one is followed by idle cycles so that the
        // per-cycle out_valid check pins the three-cycle latency.
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            set_issue(vecs[i].thread, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].mask, vecs[i].sb);
            ovr_en     = 1'b1;
            ovr_prod   = vecs[i].exp_prod;
            ovr_approx = vecs[i].exp_approx;
            applyStimulus();
            ovr_en = 1'b0;
            if (i == 0) idle(S);
        end
        idle(S + 1);

        // Mode writes racing with issue on the same thread
        drive_idle();
        stat_clear = 1'b1;
        applyStimulus();
        drive_idle();
        cfg_mode_we = 1'b1; cfg_mode_thread = 2'd1; cfg_mode_value = DTCL;
        set_issue(2'd1, MUL_F, 32'h0000_01FF, 32'd3, 16'hFFFF, 8'h21);
        ovr_en = 1'b1; ovr_prod = 64'h5FD; ovr_approx = 1'b0;
        applyStimulus();
        drive_idle();
        cfg_mode_we = 1'b1; cfg_mode_thread = 2'd1; cfg_mode_value = LB;
        set_issue(2'd1, MUL_F, 32'h0000_01FF, 32'd3, 16'hFFFF, 8'h22);
        ovr_prod = 64'h5FA; ovr_approx = 1'b1;
        applyStimulus();
        drive_idle();
        set_issue(2'd1, MUL_F, 32'd3, 32'd3, 16'hFFFF, 8'h23);
        ovr_prod = 64'h8; ovr_approx = 1'b1;
        applyStimulus();
        ovr_en = 1'b0;
        idle(S + 1);
        compare("mode_seq_exact_count", 64'(stat_fmul_exact), 64'd1);
        compare("mode_seq_approx_count", 64'(stat_fmul_approx), 64'd2);

        // Rollback of thread 1 while it sits in the first stage
        drive_idle();
        stat_clear = 1'b1;
        applyStimulus();
        drive_idle();
        set_issue(2'd0, MUL_F, 32'h0000_1234, 32'h0000_0100, 16'h000F, 8'h30);
        applyStimulus();
        drive_idle();
        set_issue(2'd1, MUL_F, 32'h0000_5678, 32'h0000_0100, 16'h00F0, 8'h31);
        applyStimulus();
        drive_idle();
        set_issue(2'd2, MUL_F, 32'h0000_9ABC, 32'h0000_0100, 16'h0F00, 8'h32);
        rollback_en = 1'b1; rollback_thread_idx = 2'd1;
        applyStimulus();
        idle(S + 1);
        compare("rollback_exact_count", 64'(stat_fmul_exact), 64'd2);
        compare("rollback_approx_count", 64'(stat_fmul_approx), 64'd0);

        // Counter saturation, then clear racing with a retiring MUL_F
        drive_idle();
        stat_clear = 1'b1;
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            drive_idle();
            set_issue(2'd0, MUL_F, $urandom, $urandom, 16'hFFFF, 8'(i));
            applyStimulus();
        end
        idle(S + 1);
        compare("sat_exact_count", 64'(stat_fmul_exact), 64'd15);
        drive_idle();
        set_issue(2'd0, MUL_F, 32'd7, 32'd9, 16'hFFFF, 8'h44);
        applyStimulus();
        idle(S - 1);
        drive_idle();
        stat_clear = 1'b1;
        applyStimulus();
        idle(1);
        compare("clear_vs_incr_exact", 64'(stat_fmul_exact), 64'd0);

        // Asynchronous reset with two ops in flight
        drive_idle();
        cfg_mode_we = 1'b1; cfg_mode_thread = 2'd1; cfg_mode_value = DTCL;
        applyStimulus();
        drive_idle();
        set_issue(2'd0, MULL_I, 32'd5, 32'd6, 16'hFFFF, 8'h50);
        applyStimulus();
        drive_idle();
        set_issue(2'd1, MUL_F, 32'h0000_01FF, 32'd3, 16'hFFFF, 8'h51);
        applyStimulus();
        drive_idle();
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        check_all_zero("postreset");
        idle(S + 1);
        drive_idle();
        set_issue(2'd1, MUL_F, 32'h0000_01FF, 32'd3, 16'hFFFF, 8'h52);
        ovr_en = 1'b1; ovr_prod = 64'h5FD; ovr_approx = 1'b0;
        applyStimulus();
        ovr_en = 1'b0;
        idle(S + 1);

        // Randomised traffic against the scoreboard
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            in_valid      = ($urandom % 4) != 0;
            in_thread_idx = TW'($urandom % NT);
            in_op         = 2'($urandom % 4);
            in_mask       = NL'($urandom);
            in_sideband   = SBW'($urandom);
            for (int l = 0; l < NL; l++) begin
                in_multiplicand[l*32 +: 32] = (($urandom % 4) == 0) ? ($urandom % 512) : $urandom;
                in_multiplier[l*32 +: 32]   = (($urandom % 4) == 0) ? ($urandom % 512) : $urandom;
            end
            cfg_mode_we         = ($urandom % 8) == 0;
            cfg_mode_thread     = TW'($urandom % NT);
            cfg_mode_value      = 2'($urandom % 4);
            rollback_en         = ($urandom % 8) == 0;
            rollback_thread_idx = TW'($urandom % NT);
            stat_clear          = ($urandom % 32) == 0;
            applyStimulus();
        end
        idle(S + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised multi-lane significand multiply pipeline for the FP/integer execute path.
- Successor to the fixed single-cycle multiply in FP execute stage 2, with four additions:
  - configurable lane count and pipeline depth;
  - per-thread multiplier mode (exact, LB approximate, DTCL approximate), programmable at runtime;
  - rollback squash at every pipeline stage;
  - retired-operation statistics counters.
- Sits between operand alignment (stage 1) and normalisation/rounding (stage 3).

Parameters:
- NUM_LANES, 16, number of vector lanes.
- MUL_STAGES, 2, register stages from input to output, legal range 1..4.
- NUM_THREADS, 4, hardware threads; THREAD_W = $clog2(NUM_THREADS).
- SIDEBAND_W, 8, opaque per-op payload (subcycle, instruction tag) carried alongside the op.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_mode_we  in  1  write the per-thread mode table.
- cfg_mode_thread  in  THREAD_W  thread whose mode is written.
- cfg_mode_value  in  2  new mode value (mul_mode_t).
- in_valid  in  1  operation issued this cycle.
- in_thread_idx  in  THREAD_W  thread of the issued op.
- in_op  in  2  MUL_F=0, MULL_I=1, MULH_U=2, MULH_I=3.
- in_mask  in  NUM_LANES  lane enable mask.
- in_multiplicand  in  NUM_LANES*32  per-lane operand A.
- in_multiplier  in  NUM_LANES*32  per-lane operand B.
- in_sideband  in  SIDEBAND_W  passed through unchanged.
- rollback_en  in  1  squash request.
- rollback_thread_idx  in  THREAD_W  thread to squash.
- out_valid  out  1  result valid.
- out_thread_idx  out  THREAD_W  thread of the result.
- out_mask  out  NUM_LANES  delayed in_mask.
- out_sideband  out  SIDEBAND_W  delayed in_sideband.
- out_product  out  NUM_LANES*64  per-lane 64-bit product.
- out_approx  out  1  result was produced by an approximate unit.
- stat_clear  in  1  zero both counters.
- stat_fmul_exact  out  STAT_W  retired exact MUL_F operations.
- stat_fmul_approx  out  STAT_W  retired approximate MUL_F operations.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all stage valids 0;
  - all pipeline data registers 0, so every out_* reads 0;
  - mode table all EXACT;
  - both counters 0.
  - Reset asserted mid-operation discards all in-flight ops with no output.
- Mode table:
  - One register per thread. Written on the clock edge when cfg_mode_we is high.
  - Mode 3 is reserved and treated as EXACT.
  - The mode is sampled at issue. An op issued in the same cycle as a write to its own thread uses the old mode.
  - Ops already in flight are unaffected by later writes.
- Per-lane product, computed in the first stage:
  - Operands are sign-extended to 64 bits only for MULH_I; otherwise zero-extended.
  - Integer ops (MULL_I, MULH_U, MULH_I) always produce the exact 64-bit product.
  - MUL_F with mode EXACT: exact unsigned 32x32 product.
  - MUL_F with mode LB: LB_AFPM_lite result.
  - MUL_F with mode DTCL: DTCL_AFPM_lite result.
  - out_approx = (op == MUL_F) && mode is LB or DTCL.
  - Masked-off lanes are still computed. Downstream honours out_mask.
- Latency:
  - Exactly MUL_STAGES cycles: an op issued at edge N appears with out_valid high after edge N+MUL_STAGES.
  - Throughput is one op per cycle; there is no backpressure.
  - The exact multiply may be retimed across stages, but the result must be bit-identical.
- Rollback:
  - When rollback_en is high, every stage valid whose thread == rollback_thread_idx is cleared at the next edge, including the op being issued that cycle.
  - The output register is also covered: a matching op that would appear next cycle is suppressed.
  - Ops of other threads are unaffected.
  - Data registers are not cleared by rollback.
- Statistics:
  - On each cycle with out_valid && out_op == MUL_F, exactly one counter increments: stat_fmul_approx if out_approx, else stat_fmul_exact.
  - Counters saturate at all-ones.
  - stat_clear has priority over a simultaneous increment (result 0).
  - Squashed ops never count.

Decomposition:
- Shared package fp_mul_pkg holds:
  - mul_mode_t enum (EXACT=0, LB=1, DTCL=2, RSVD=3);
  - mul_op_t enum;
  - MUL_STAGES_MAX=4.
- Natural sub-module: fp_mul_lane, the per-lane operand extension, the exact/LB/DTCL units and the result select (combinational). It is instantiated NUM_LANES times with a generate loop.
- The parent fp_mul_pipe holds the stage registers, mode table, squash logic and counters.

Test Plan:
- MUL_STAGES=3, MULH_I, A=0xFFFFFFFE, B=3, issued at cycle 0 -> out_valid only at cycle 3; product 0xFFFFFFFF_FFFFFFFA; out_approx=0.
- MULL_I A=B=0x00010000 on all lanes, mask 0x00FF -> product 0x00000001_00000000 on every lane; out_mask=0x00FF; sideband echoed.
- Write thread 1 mode=DTCL, then issue MUL_F on thread 1 in the same cycle as a second write, then issue again:
  - first op uses the prior mode;
  - next op out_approx=1, product equals the DTCL_AFPM_lite model;
  - stat_fmul_approx increments by 1.
- Back-to-back issue of threads 0, 1, 2 with rollback of thread 1 while it is in stage 1 -> outputs only for threads 0 and 2, in order, with no gap shift; counters ignore thread 1.
- STAT_W=4, issue 20 exact MUL_F ops -> stat_fmul_exact holds at 15. Then stat_clear concurrent with a retiring MUL_F -> counter reads 0.
- Drop reset_n with 2 ops in flight, release after 1 cycle -> no out_valid, all outputs 0, mode table back to EXACT.
